// File: rtl/oob_ctrl.sv
// SATA OOB link controller: issues OOB start requests, retries with backoff,
// tracks the linked state and detects link loss via rxelecidle or COMINIT.
module oob_ctrl #(
  parameter int unsigned CLK_SPEED_GRADE = 2,
  parameter int unsigned RETRY_LIMIT     = 4,
  parameter int unsigned RETRY_GAP       = 1024,
  parameter int unsigned WAIT_LIMIT      = 1048575,
  parameter int unsigned IDLE_LIMIT      = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gtx_ready,
  input  logic       restart,
  input  logic       link_up,
  input  logic       oob_silence,
  input  logic       oob_error,
  input  logic       oob_incompatible,
  input  logic       cominit_req,
  input  logic       rxelecidle,
  output logic       oob_start,
  output logic       cominit_allow,
  output logic       phy_ready,
  output logic       link_lost,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  localparam int unsigned RW = 4;
  localparam int unsigned GW = 16;
  localparam int unsigned WW = 20;
  localparam int unsigned IW = 8;

  // Reject out-of-range parameters at elaboration.
  if (!(CLK_SPEED_GRADE == 1 || CLK_SPEED_GRADE == 2 || CLK_SPEED_GRADE == 4) ||
      RETRY_LIMIT > 15 || RETRY_GAP < 1 || RETRY_GAP > 65535 ||
      WAIT_LIMIT < 1 || WAIT_LIMIT > 1048575 || IDLE_LIMIT < 1 || IDLE_LIMIT > 255) begin : g_bad_param
    $error("oob_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_LINKED  = 3'd4,
    ST_FAILED  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          oob_start_q, oob_start_d;
  logic          cominit_allow_q, cominit_allow_d;
  logic          phy_ready_q, phy_ready_d;
  logic          link_lost_q, link_lost_d;
  logic          fail_q, fail_d;

  logic [WW-1:0] wd_inc;
  logic [IW-1:0] idle_inc;
  logic [RW-1:0] retry_inc;
  logic          oob_bad;

  // Saturating increments.
  assign wd_inc    = (wd_q == '1)    ? wd_q    : wd_q + WW'(1);
  assign idle_inc  = (idle_q == '1)  ? idle_q  : idle_q + IW'(1);
  assign retry_inc = (retry_q == '1) ? retry_q : retry_q + RW'(1);
  assign oob_bad   = oob_silence | oob_error | oob_incompatible;

  always_comb begin
    state_d         = state_q;
    retry_d         = retry_q;
    gap_d           = gap_q;
    wd_d            = wd_q;
    idle_d          = idle_q;
    oob_start_d     = 1'b0;
    cominit_allow_d = 1'b0;
    link_lost_d     = 1'b0;
    phy_ready_d     = phy_ready_q;
    fail_d          = fail_q;

    if (!gtx_ready) begin
      state_d     = ST_IDLE;
      retry_d     = '0;
      gap_d       = '0;
      wd_d        = '0;
      idle_d      = '0;
      phy_ready_d = 1'b0;
      fail_d      = 1'b0;
    end else if (restart && state_q != ST_IDLE) begin
      state_d     = ST_START;
      retry_d     = '0;
      gap_d       = '0;
      wd_d        = '0;
      idle_d      = '0;
      phy_ready_d = 1'b0;
      fail_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_START;
        ST_START: begin
          if (cominit_req) cominit_allow_d = 1'b1;
          else             oob_start_d     = 1'b1;
          state_d = ST_WAIT;
          wd_d    = '0;
        end
        ST_WAIT: begin
          if (link_up) begin
            state_d     = ST_LINKED;
            retry_d     = '0;
            idle_d      = '0;
            phy_ready_d = 1'b1;
          end else if (oob_bad || wd_inc == WW'(WAIT_LIMIT)) begin
            if (retry_q == RW'(RETRY_LIMIT)) begin
              state_d = ST_FAILED;
              fail_d  = 1'b1;
            end else begin
              state_d = ST_BACKOFF;
              retry_d = retry_inc;
              gap_d   = '0;
            end
          end else begin
            wd_d = wd_inc;
          end
        end
        ST_BACKOFF: begin
          // A device COMINIT during backoff is answered directly.
          if (cominit_req) begin
            cominit_allow_d = 1'b1;
            state_d         = ST_WAIT;
            wd_d            = '0;
          end else if (gap_q == GW'(RETRY_GAP - 1)) begin
            state_d = ST_START;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        ST_LINKED: begin
          if (cominit_req) begin
            link_lost_d     = 1'b1;
            cominit_allow_d = 1'b1;
            phy_ready_d     = 1'b0;
            state_d         = ST_WAIT;
            wd_d            = '0;
            idle_d          = '0;
          end else if (rxelecidle) begin
            if (idle_inc == IW'(IDLE_LIMIT)) begin
              link_lost_d = 1'b1;
              phy_ready_d = 1'b0;
              retry_d     = '0;
              state_d     = ST_START;
              idle_d      = '0;
            end else begin
              idle_d = idle_inc;
            end
          end else begin
            idle_d = '0;
          end
        end
        ST_FAILED: begin
          fail_d      = 1'b1;
          phy_ready_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      retry_q         <= '0;
      gap_q           <= '0;
      wd_q            <= '0;
      idle_q          <= '0;
      oob_start_q     <= 1'b0;
      cominit_allow_q <= 1'b0;
      phy_ready_q     <= 1'b0;
      link_lost_q     <= 1'b0;
      fail_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      retry_q         <= retry_d;
      gap_q           <= gap_d;
      wd_q            <= wd_d;
      idle_q          <= idle_d;
      oob_start_q     <= oob_start_d;
      cominit_allow_q <= cominit_allow_d;
      phy_ready_q     <= phy_ready_d;
      link_lost_q     <= link_lost_d;
      fail_q          <= fail_d;
    end
  end

  assign oob_start     = oob_start_q;
  assign cominit_allow = cominit_allow_q;
  assign phy_ready     = phy_ready_q;
  assign link_lost     = link_lost_q;
  assign fail          = fail_q;
  assign retry_cnt     = retry_q;
  assign state         = state_q;

endmodule

// File: tb/tb_oob_ctrl.sv
// Bench for oob_ctrl: vector table through a scoreboard queue, then
// hand-written idle-count, watchdog and asynchronous-reset sequences.
module tb_oob_ctrl;

  localparam int unsigned RL  = 2;
  localparam int unsigned GAP = 8;
  localparam int unsigned WL  = 50;
  localparam int unsigned IL  = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       gtx_ready = 1'b0, restart = 1'b0, link_up = 1'b0;
  logic       oob_silence = 1'b0, oob_error = 1'b0, oob_incompatible = 1'b0;
  logic       cominit_req = 1'b0, rxelecidle = 1'b0;
  logic       oob_start, cominit_allow, phy_ready, link_lost, fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  oob_ctrl #(
    .CLK_SPEED_GRADE(2), .RETRY_LIMIT(RL), .RETRY_GAP(GAP),
    .WAIT_LIMIT(WL), .IDLE_LIMIT(IL)
  ) dut (
    .clk(clk), .rst(rst), .gtx_ready(gtx_ready), .restart(restart),
    .link_up(link_up), .oob_silence(oob_silence), .oob_error(oob_error),
    .oob_incompatible(oob_incompatible), .cominit_req(cominit_req),
    .rxelecidle(rxelecidle), .oob_start(oob_start), .cominit_allow(cominit_allow),
    .phy_ready(phy_ready), .link_lost(link_lost), .fail(fail),
    .retry_cnt(retry_cnt), .state(state)
  );

  always #5 clk = ~clk;

  // Input bits: {gtx_ready, restart, link_up, silence, error, incompat, cominit_req, rxelecidle}
  typedef logic [7:0] in_t;
  localparam in_t G   = 8'h80;
  localparam in_t RS  = 8'h40;
  localparam in_t LU  = 8'h20;
  localparam in_t SIL = 8'h10;
  localparam in_t ERR = 8'h08;
  localparam in_t INC = 8'h04;
  localparam in_t CI  = 8'h02;
  localparam in_t EI  = 8'h01;

  typedef struct packed {
    logic       os, ca, pr, ll, f;
    logic [3:0] rc;
    logic [2:0] st;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    string nm;
  } vec_t;

  vec_t  tbl[$];
  out_t  exp_q[$];
  string nm_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic out_t o(input logic os, ca, pr, ll, f, input int rc, input int st);
    out_t r;
    r.os = os; r.ca = ca; r.pr = pr; r.ll = ll; r.f = f;
    r.rc = 4'(rc); r.st = 3'(st);
    return r;
  endfunction

  function automatic out_t cur();
    out_t r;
    r.os = oob_start; r.ca = cominit_allow; r.pr = phy_ready; r.ll = link_lost;
    r.f = fail; r.rc = retry_cnt; r.st = state;
    return r;
  endfunction

  function automatic void add(input in_t i, input out_t e, input string nm);
    vec_t v;
    v.i = i; v.o = e; v.nm = nm;
    tbl.push_back(v);
  endfunction

  task automatic check(input string nm, input out_t e);
    out_t a;
    a = cur();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got {os,ca,pr,ll,f,rc,st}=%b_%b_%b_%b_%b_%0d_%0d want %b_%b_%b_%b_%b_%0d_%0d",
               nm, a.os, a.ca, a.pr, a.ll, a.f, a.rc, a.st,
               e.os, e.ca, e.pr, e.ll, e.f, e.rc, e.st);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input in_t i, input out_t e, input string nm);
    {gtx_ready, restart, link_up, oob_silence, oob_error, oob_incompatible,
     cominit_req, rxelecidle} = i;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    check(nm_q.pop_front(), exp_q.pop_front());
  endtask

  initial begin
    add(0,       o(0,0,0,0,0,0,0), "idle_no_gtx");
    add(G,       o(0,0,0,0,0,0,1), "idle_to_start");
    add(G,       o(1,0,0,0,0,0,2), "start_oob");
    add(G | SIL, o(0,0,0,0,0,1,3), "wait_silence");
    for (int k = 0; k < GAP - 1; k++) add(G, o(0,0,0,0,0,1,3), "backoff_1");
    add(G,       o(0,0,0,0,0,1,1), "gap1_to_start");
    add(G,       o(1,0,0,0,0,1,2), "retry1_oob");
    add(G | ERR, o(0,0,0,0,0,2,3), "wait_error");
    for (int k = 0; k < GAP - 1; k++) add(G, o(0,0,0,0,0,2,3), "backoff_2");
    add(G,       o(0,0,0,0,0,2,1), "gap2_to_start");
    add(G,       o(1,0,0,0,0,2,2), "retry2_oob");
    add(G | INC, o(0,0,0,0,1,2,5), "retries_exhausted");
    add(G | CI,  o(0,0,0,0,1,2,5), "failed_ignores_ci");
    add(G | RS,  o(0,0,0,0,0,0,1), "restart_from_failed");
    add(G,       o(1,0,0,0,0,0,2), "restart_oob");
    add(G | LU | ERR, o(0,0,1,0,0,0,4), "link_up_beats_error");
    add(G | CI,  o(0,1,0,1,0,0,2), "linked_cominit");
    add(G | LU,  o(0,0,1,0,0,0,4), "relink");
    add(0,       o(0,0,0,0,0,0,0), "gtx_drop_linked");
    add(G,       o(0,0,0,0,0,0,1), "idle_to_start_2");
    add(G | CI,  o(0,1,0,0,0,0,2), "start_cominit");
    add(G | SIL, o(0,0,0,0,0,1,3), "fail_after_cominit");
    add(G | CI,  o(0,1,0,0,0,1,2), "backoff_cominit");
    add(0,       o(0,0,0,0,0,0,0), "gtx_drop_wait");
    add(G,       o(0,0,0,0,0,0,1), "idle_to_start_3");
    add(G | RS,  o(0,0,0,0,0,0,1), "restart_in_start");
    add(G,       o(1,0,0,0,0,0,2), "start_oob_3");
    add(G | LU,  o(0,0,1,0,0,0,4), "link_up");

    #2;
    check("reset_values", o(0,0,0,0,0,0,0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[n]) step(tbl[n].i, tbl[n].o, tbl[n].nm);

    // rxelecidle one short of the limit, a break, then exactly the limit.
    for (int k = 0; k < IL - 1; k++) step(G | EI, o(0,0,1,0,0,0,4), "idle_below_limit");
    step(G, o(0,0,1,0,0,0,4), "idle_break");
    for (int k = 0; k < IL - 1; k++) step(G | EI, o(0,0,1,0,0,0,4), "idle_count_again");
    step(G | EI, o(0,0,0,1,0,0,1), "idle_link_lost");
    step(G,      o(1,0,0,0,0,0,2), "link_lost_single_pulse");

    // Watchdog expiry after WAIT_LIMIT cycles in WAIT.
    for (int k = 0; k < WL - 1; k++) step(G, o(0,0,0,0,0,0,2), "watchdog_wait");
    step(G, o(0,0,0,0,0,1,3), "watchdog_expire");
    for (int k = 0; k < GAP - 1; k++) step(G, o(0,0,0,0,0,1,3), "watchdog_backoff");
    step(G,      o(0,0,0,0,0,1,1), "watchdog_restart");
    step(G,      o(1,0,0,0,0,1,2), "watchdog_oob");
    step(G | LU, o(0,0,1,0,0,0,4), "watchdog_relink");

    // Asynchronous reset mid-cycle while linked.
    #3;
    rst = 1'b0;
    #1;
    check("async_reset_no_edge", o(0,0,0,0,0,0,0));
    @(posedge clk);
    #1;
    check("reset_held", o(0,0,0,0,0,0,0));
    #3;
    rst = 1'b1;
    step(G, o(0,0,0,0,0,0,1), "first_edge_after_reset");
    step(G, o(1,0,0,0,0,0,2), "oob_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
